// File: rtl/iki_bir_mux_hakem_pkg.sv
// Shared encodings for the 2:1 mux arbiter and the mux wrapper.
// State codes and select values live here so both sides agree.
package iki_bir_mux_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_A = 2'd1;
  localparam logic [1:0] ST_GNT_B = 2'd2;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef logic [1:0] hakem_st_t;

endpackage

// File: rtl/iki_bir_mux_hakem_if.sv
// Request/grant bundle between two requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface iki_bir_mux_hakem_if;
  logic req_a;
  logic req_b;
  logic gnt_a;
  logic gnt_b;
  logic sel;
  logic busy;
  logic last_a;

  modport master (
    output req_a, req_b,
    input  gnt_a, gnt_b, sel, busy, last_a
  );

  modport slave (
    input  req_a, req_b,
    output gnt_a, gnt_b, sel, busy, last_a
  );
endinterface

// File: rtl/iki_bir_mux_hakem_burst_sayac.sv
// Tenure length counter: load 1, count up, stick at MAX_BURST.
// at_max tells the arbiter the owner has used its full burst.
module burst_sayac #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic at_max
);

  logic [CNT_W-1:0] cnt;

  assign at_max = (cnt == CNT_W'(MAX_BURST));

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= CNT_W'(1);
    else if (inc && !at_max)
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/iki_bir_mux_hakem.sv
// Round-robin arbiter for the shared 2:1 mux with burst limit.
// sel drives the mux enable: 0 = A path, 1 = B path.
module iki_bir_mux_hakem
  import iki_bir_mux_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input logic clk,
  input logic rst,
  iki_bir_mux_hakem_if.slave bus
);

  hakem_st_t state_q, state_d;
  logic      sel_q, sel_d;
  logic      last_q, last_d;
  logic      at_max;
  logic      cnt_load, cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_A;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_GNT_A: begin
        if (!bus.req_a)
          state_d = bus.req_b ? ST_GNT_B : ST_IDLE;
        else if (bus.req_b && at_max)
          state_d = ST_GNT_B;
      end
      ST_GNT_B: begin
        if (!bus.req_b)
          state_d = bus.req_a ? ST_GNT_A : ST_IDLE;
        else if (bus.req_a && at_max)
          state_d = ST_GNT_A;
      end
      default: begin
        if (bus.req_a && bus.req_b)
          state_d = last_q ? ST_GNT_B : ST_GNT_A;
        else if (bus.req_a)
          state_d = ST_GNT_A;
        else if (bus.req_b)
          state_d = ST_GNT_B;
      end
    endcase
  end

  // Pointer and select only move on a grant entry; IDLE keeps them.
  always_comb begin
    sel_d    = sel_q;
    last_d   = last_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    if (state_d != state_q && state_d != ST_IDLE) begin
      cnt_load = 1'b1;
      sel_d    = (state_d == ST_GNT_B) ? SEL_B : SEL_A;
      last_d   = (state_d == ST_GNT_A);
    end else if (state_d == state_q && state_q != ST_IDLE) begin
      cnt_inc = 1'b1;
    end
  end

  always_comb begin
    bus.gnt_a  = (state_q == ST_GNT_A);
    bus.gnt_b  = (state_q == ST_GNT_B);
    bus.busy   = (state_q != ST_IDLE);
    bus.sel    = sel_q;
    bus.last_a = last_q;
  end

  burst_sayac #(
    .MAX_BURST(MAX_BURST),
    .CNT_W    (CNT_W)
  ) u_sayac (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .inc   (cnt_inc),
    .at_max(at_max)
  );

endmodule
